// File: rtl/pwm_sar_multichannel_if.sv
// Control and result bundle for the multi-channel PWM SAR converter.
//   slave  : converter side (takes run controls + comparator, drives code/mux/results)
//   master : controller/testbench side (drives run controls + comparator, observes outputs)
// Ports: enable, mode, start, comparator_in | current_duty_cycle, mux_sel,
//        results, result_valid, result_channel, busy
interface pwm_sar_multichannel_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                      enable;
  logic                      mode;
  logic                      start;
  logic                      comparator_in;
  logic [WIDTH-1:0]          current_duty_cycle;
  logic [SEL_W-1:0]          mux_sel;
  logic [CHANNELS*WIDTH-1:0] results;
  logic                      result_valid;
  logic [SEL_W-1:0]          result_channel;
  logic                      busy;

  modport slave (
    input  enable, mode, start, comparator_in,
    output current_duty_cycle, mux_sel, results, result_valid, result_channel, busy
  );

  modport master (
    output enable, mode, start, comparator_in,
    input  current_duty_cycle, mux_sel, results, result_valid, result_channel, busy
  );
endinterface

// File: rtl/pwm_sar_multichannel.sv
// Time-shared PWM SAR converter: one DAC/comparator pair, CHANNELS muxed inputs, 2^AVG_LOG2 averaging.
// Latency: per channel 2^AVG_LOG2*(WIDTH*(SETTLE_CYCLES+1)+1)+1 cycles from first SETTLE to PUBLISH; result_valid one cycle later.
// Backpressure: none; start is ignored while busy, enable low aborts to IDLE keeping published results.
// Ports: clk, reset (sync, active-low), bus (slave modport: run controls, comparator in; code, mux, results out).
module pwm_sar_multichannel #(
  parameter int WIDTH         = 8,
  parameter int CHANNELS      = 4,
  parameter int SETTLE_CYCLES = 1024,
  parameter int AVG_LOG2      = 2
) (
  input logic                   clk,
  input logic                   reset,
  pwm_sar_multichannel_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = WIDTH + AVG_LOG2;
  localparam int SC_W  = $clog2(SETTLE_CYCLES);
  localparam int CV_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CV_W-1:0]  CONV_LAST   = CV_W'((1 << AVG_LOG2) - 1);
  localparam logic [SEL_W-1:0] CH_LAST     = SEL_W'(CHANNELS - 1);
  localparam logic [WIDTH-1:0] MSB         = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, SETTLE, DECIDE, ACCUM, PUBLISH} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sync_q;
  logic [WIDTH-1:0]          duty_q, duty_d;
  logic [WIDTH-1:0]          mask_q, mask_d;
  logic [SEL_W-1:0]          ch_q, ch_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [CV_W-1:0]           conv_q, conv_d;
  logic [SC_W-1:0]           settle_q, settle_d;
  logic [CHANNELS*WIDTH-1:0] results_q, results_d;
  logic                      rv_q, rv_d;
  logic [SEL_W-1:0]          rch_q, rch_d;
  logic [WIDTH-1:0]          trial;
  logic [ACC_W-1:0]          avg;
  logic                      comp_s;

  assign comp_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    acc_d     = acc_q;
    conv_d    = conv_q;
    settle_d  = settle_q;
    results_d = results_q;
    rv_d      = 1'b0;
    rch_d     = rch_q;
    trial     = duty_q;
    avg       = acc_q >> AVG_LOG2;

    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (bus.enable && (bus.mode || bus.start)) begin
          state_d  = SETTLE;
          ch_d     = '0;
          acc_d    = '0;
          conv_d   = '0;
          mask_d   = MSB;
          duty_d   = MSB;
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) state_d = DECIDE;
        else                         settle_d = settle_q + 1'b1;
      end
      DECIDE: begin
        // comparator low means the input is below the trial code: drop the bit
        if (!comp_s) trial = duty_q & ~mask_q;
        duty_d = trial;
        if (mask_q[0]) begin
          state_d = ACCUM;
        end else begin
          mask_d   = mask_q >> 1;
          duty_d   = trial | (mask_q >> 1);
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      ACCUM: begin
        acc_d = acc_q + ACC_W'(duty_q);
        if (conv_q == CONV_LAST) begin
          state_d = PUBLISH;
        end else begin
          conv_d   = conv_q + 1'b1;
          mask_d   = MSB;
          duty_d   = MSB;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      PUBLISH: begin
        results_d[ch_q*WIDTH +: WIDTH] = avg[WIDTH-1:0];
        rch_d = ch_q;
        rv_d  = 1'b1;
        // mode is only looked at here, so a mid-sweep change waits for this decision
        if (ch_q == CH_LAST && !bus.mode) begin
          state_d = IDLE;
          duty_d  = '0;
        end else begin
          ch_d     = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          acc_d    = '0;
          conv_d   = '0;
          mask_d   = MSB;
          duty_d   = MSB;
          settle_d = '0;
          state_d  = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // abort wins over everything: discard the partial conversion, keep published results
    if (!bus.enable) begin
      state_d   = IDLE;
      duty_d    = '0;
      rv_d      = 1'b0;
      results_d = results_q;
      rch_d     = rch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      duty_q    <= '0;
      mask_q    <= '0;
      ch_q      <= '0;
      acc_q     <= '0;
      conv_q    <= '0;
      settle_q  <= '0;
      results_q <= '0;
      rv_q      <= 1'b0;
      rch_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], bus.comparator_in};
      duty_q    <= duty_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      acc_q     <= acc_d;
      conv_q    <= conv_d;
      settle_q  <= settle_d;
      results_q <= results_d;
      rv_q      <= rv_d;
      rch_q     <= rch_d;
    end
  end

  assign bus.current_duty_cycle = duty_q;
  assign bus.mux_sel            = ch_q;
  assign bus.results            = results_q;
  assign bus.result_valid       = rv_q;
  assign bus.result_channel     = rch_q;
  assign bus.busy               = (state_q != IDLE);
endmodule

// File: tb/tb_pwm_sar_multichannel.sv
// Bench for pwm_sar_multichannel: two instances (2ch/no averaging, 3ch/4x averaging), SETTLE_CYCLES=4.
// Comparator modelled as (V[mux_sel] >= current_duty_cycle); expected results come from the ideal SAR
// outcome (the input code itself) and plain-arithmetic averaging of the per-conversion inputs.
module tb_pwm_sar_multichannel;
  localparam int S      = 4;
  localparam int CONV   = 8 * (S + 1) + 1;     // 41 cycles per conversion
  localparam int CH_A   = CONV + 1;            // 42: channel period, no averaging
  localparam int CH_B   = 4 * CONV + 1;        // 165: channel period, 4x averaging

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_sar_multichannel_if #(.WIDTH(8), .CHANNELS(2)) ifa ();
  pwm_sar_multichannel_if #(.WIDTH(8), .CHANNELS(3)) ifb ();

  pwm_sar_multichannel #(.WIDTH(8), .CHANNELS(2), .SETTLE_CYCLES(S), .AVG_LOG2(0))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pwm_sar_multichannel #(.WIDTH(8), .CHANNELS(3), .SETTLE_CYCLES(S), .AVG_LOG2(2))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  logic [7:0] va [2];
  logic [7:0] vb [4];
  assign ifa.comparator_in = (va[ifa.mux_sel] >= ifa.current_duty_cycle);
  assign ifb.comparator_in = (vb[ifb.mux_sel] >= ifb.current_duty_cycle);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qa[$], tva[$], qb[$], tvb[$];
  always @(negedge clk) begin
    if (ifa.result_valid) begin qa.push_back(int'(ifa.result_channel)); tva.push_back(cyc); end
    if (ifb.result_valid) begin qb.push_back(int'(ifb.result_channel)); tvb.push_back(cyc); end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int t0a, t0b;
  logic [7:0] trace [400];
  logic [7:0] sb [3][4];

  typedef struct {
    logic [7:0] v0, v1;
    logic [7:0] r0, r1;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_duty_a"}, ifa.current_duty_cycle, 0);
    chk({tag, "_mux_a"}, ifa.mux_sel, 0);
    chk({tag, "_res_a"}, ifa.results, 0);
    chk({tag, "_rv_a"}, ifa.result_valid, 0);
    chk({tag, "_rch_a"}, ifa.result_channel, 0);
    chk({tag, "_busy_a"}, ifa.busy, 0);
  endtask

  task automatic chk_zero_b(input string tag);
    chk({tag, "_duty_b"}, ifb.current_duty_cycle, 0);
    chk({tag, "_mux_b"}, ifb.mux_sel, 0);
    chk({tag, "_res_b"}, ifb.results, 0);
    chk({tag, "_rv_b"}, ifb.result_valid, 0);
    chk({tag, "_rch_b"}, ifb.result_channel, 0);
    chk({tag, "_busy_b"}, ifb.busy, 0);
  endtask

  // One single-mode sweep of dut_a; the duty code is traced per cycle relative to the first SETTLE cycle.
  task automatic sweep_a();
    int k;
    qa.delete(); tva.delete();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    t0a = cyc;
    chk("a_busy_rise", ifa.busy, 1);
    k = 0;
    while (qa.size() < 2 && k < 300) begin
      trace[k] = ifa.current_duty_cycle;
      tick();
      k++;
    end
    chk("a_sweep_done_in_budget", (k < 300), 1);
  endtask

  // Single-mode sweep of dut_b; vb[ch] steps through sb[ch][*] at each conversion boundary.
  task automatic sweep_b();
    int k, pos;
    qb.delete(); tvb.delete();
    for (int c = 0; c < 3; c++) vb[c] = sb[c][0];
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    t0b = cyc;
    k = 0;
    while (qb.size() < 3 && k < 800) begin
      k   = cyc - t0b;
      pos = k % CH_B;
      if (k < 3 * CH_B && pos < CH_B - 1 && pos % CONV == 0) vb[k / CH_B] = sb[k / CH_B][pos / CONV];
      tick();
    end
    chk("b_sweep_done_in_budget", (k < 800), 1);
  endtask

  function automatic logic [7:0] avg_ref(input int ch);
    int sum = 0;
    for (int i = 0; i < 4; i++) sum += int'(sb[ch][i]);
    return 8'(sum / 4);
  endfunction

  initial begin
    tbl[0] = '{v0: 8'hA5, v1: 8'h3C, r0: 8'hA5, r1: 8'h3C};
    tbl[1] = '{v0: 8'h00, v1: 8'hFF, r0: 8'h00, r1: 8'hFF};
    tbl[2] = '{v0: 8'h80, v1: 8'h7F, r0: 8'h80, r1: 8'h7F};
    tbl[3] = '{v0: 8'h01, v1: 8'hFE, r0: 8'h01, r1: 8'hFE};
    tbl[4] = '{v0: 8'h55, v1: 8'hAA, r0: 8'h55, r1: 8'hAA};
    va[0] = 8'h00; va[1] = 8'h00;
    for (int i = 0; i < 4; i++) vb[i] = 8'h00;

    // Reset with random inputs, then release with enable low
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifa.enable = 1'($urandom); ifa.mode = 1'($urandom); ifa.start = 1'($urandom);
      ifb.enable = 1'($urandom); ifb.mode = 1'($urandom); ifb.start = 1'($urandom);
      va[0] = 8'($urandom); va[1] = 8'($urandom); vb[0] = 8'($urandom);
      tick();
    end
    chk_zero_a("rst");
    chk_zero_b("rst");
    ifa.enable = 1'b0; ifb.enable = 1'b0;
    ifa.mode = 1'b0; ifb.mode = 1'b0; ifa.start = 1'b0; ifb.start = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_zero_a("rel");
    chk_zero_b("rel");

    // Table-driven single sweeps on dut_a
    ifa.enable = 1'b1;
    tick();
    foreach (tbl[i]) begin
      va[0] = tbl[i].v0; va[1] = tbl[i].v1;
      sweep_a();
      chk("a_chan_seq0", qa[0], 0);
      chk("a_chan_seq1", qa[1], 1);
      chk("a_valid0_latency", tva[0] - t0a, CH_A);
      chk("a_valid_gap", tva[1] - tva[0], CH_A);
      chk("a_results", ifa.results, {tbl[i].r1, tbl[i].r0});
      chk("a_busy_fall", ifa.busy, 0);
    end

    // Boundaries: trial sequence for V=0x00 (ch0) and V=0xFF (ch1)
    va[0] = 8'h00; va[1] = 8'hFF;
    sweep_a();
    for (int b = 0; b < 8; b++) begin
      chk("trial_v00", trace[b * (S + 1) + 1], 8'h80 >> b);
      chk("trial_vff", trace[CH_A + b * (S + 1) + 1], 8'hFF & (8'hFF << (7 - b)));
    end
    chk("bound_res", ifa.results, 16'hFF00);

    // Abort in the middle of bit 3 of channel 1
    va[0] = 8'h5A; va[1] = 8'hC3;
    sweep_a();
    va[0] = 8'h21; va[1] = 8'h43;
    qa.delete(); tva.delete();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    t0a = cyc;
    for (int i = 0; i < 200 && (cyc - t0a) < CH_A + 3 * (S + 1) + 2; i++) tick();
    chk("abort_at_ch1", ifa.mux_sel, 1);
    ifa.enable = 1'b0;
    tick();
    chk("abort_busy", ifa.busy, 0);
    chk("abort_duty", ifa.current_duty_cycle, 0);
    chk("abort_res1_kept", ifa.results[15:8], 8'hC3);
    chk("abort_res0_new", ifa.results[7:0], 8'h21);
    for (int i = 0; i < 60; i++) tick();
    chk("abort_valid_count", qa.size(), 1);
    ifa.enable = 1'b1;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    chk("restart_mux0", ifa.mux_sel, 0);
    chk("restart_busy", ifa.busy, 1);
    for (int i = 0; i < 200 && ifa.busy; i++) tick();
    chk("restart_res", ifa.results, 16'h4321);
    chk("restart_chan_first", qa[1], 0);

    // Averaging on dut_b: ch0 steps 0x10..0x13, other channels random steps
    ifb.enable = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++)
        for (int j = 0; j < 4; j++) sb[c][j] = 8'($urandom);
      if (r == 0) begin
        sb[0][0] = 8'h10; sb[0][1] = 8'h11; sb[0][2] = 8'h12; sb[0][3] = 8'h13;
      end
      sweep_b();
      chk("b_valid_count", qb.size(), 3);
      for (int c = 0; c < 3; c++) begin
        chk("b_chan_seq", qb[c], c);
        chk("b_avg_result", ifb.results[c * 8 +: 8], avg_ref(c));
      end
      chk("b_valid0_latency", tvb[0] - t0b, CH_B);
      if (r == 0) chk("b_avg_0x11", ifb.results[7:0], 8'h11);
    end

    // Continuous mode wrap, then reset mid-conversion
    vb[0] = 8'h12; vb[1] = 8'h9E; vb[2] = 8'hE7;
    qb.delete(); tvb.delete();
    ifb.mode = 1'b1;
    for (int i = 0; i < 1200 && qb.size() < 5; i++) tick();
    chk("cont_count", (qb.size() >= 5), 1);
    for (int i = 0; i < 5 && i < qb.size(); i++) chk("cont_chan", qb[i], i % 3);
    for (int i = 0; i < 4 && i + 1 < tvb.size(); i++) chk("cont_gap", tvb[i + 1] - tvb[i], CH_B);
    chk("cont_res2", ifb.results[23:16], 8'hE7);
    for (int i = 0; i < 37; i++) tick();
    chk("cont_busy_before_rst", ifb.busy, 1);
    reset = 1'b0;
    tick();
    chk_zero_b("midrst");
    chk_zero_a("midrst");
    ifb.enable = 1'b0;
    reset = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
